// File: rtl/riscv_pkg.sv
// Shared definitions for the single-cycle RV32I-subset core: opcodes, function codes,
// ALU operations, the decoded control bundle and the built-in boot program.
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int ROM_WORDS = 64;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;

    localparam logic [2:0] F3_ADD_SUB = 3'h0;
    localparam logic [2:0] F3_SLT     = 3'h2;
    localparam logic [2:0] F3_OR      = 3'h6;
    localparam logic [2:0] F3_AND     = 3'h7;
    localparam logic [2:0] F3_WORD    = 3'h2;
    localparam logic [2:0] F3_BEQ     = 3'h0;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_SUB  = 7'h20;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    typedef struct packed {
        logic    reg_we;
        logic    alu_src;
        logic    mem_we;
        logic    mem_to_reg;
        logic    branch;
        alu_op_t alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        reg_we:     1'b0,
        alu_src:    1'b0,
        mem_we:     1'b0,
        mem_to_reg: 1'b0,
        branch:     1'b0,
        alu_op:     ALU_ADD
    };

    typedef logic [ROM_WORDS-1:0][31:0] rom_image_t;

    function automatic rom_image_t default_rom();
        rom_image_t r;
        for (int i = 0; i < ROM_WORDS; i++) r[i] = NOP_INSN;
        r[0] = 32'h0020_0093;  // addi x1,x0,2
        r[1] = 32'h0040_0113;  // addi x2,x0,4
        r[2] = 32'h4011_01B3;  // sub  x3,x2,x1
        r[3] = 32'h4031_0233;  // sub  x4,x2,x3
        r[4] = 32'h0020_82B3;  // add  x5,x1,x2
        r[5] = 32'h4012_8333;  // sub  x6,x5,x1
        return r;
    endfunction

    localparam rom_image_t DEFAULT_ROM = default_rom();

endpackage

// File: rtl/riscv_datapath.sv
// Single-cycle datapath: PC, instruction ROM, decoder, register file, ALU and data RAM.
// Everything between two rising edges is combinational; the edge retires one instruction.
module riscv_datapath
    import riscv_pkg::*;
#(
    parameter int              XLEN       = riscv_pkg::XLEN,
    parameter int              IMEM_DEPTH = 64,
    parameter int              DMEM_DEPTH = 64,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter rom_image_t      ROM_IMAGE  = DEFAULT_ROM
) (
    input logic clk,
    input logic rst
);

    localparam int              IADDR_W = $clog2(IMEM_DEPTH);
    localparam int              DADDR_W = $clog2(DMEM_DEPTH);
    localparam logic [XLEN-1:0] PC_MASK = XLEN'(IMEM_DEPTH * 4 - 1);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [31:0]     instr;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    ctrl_t           ctrl;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wb_data;
    logic            branch_taken;

    logic [XLEN-1:0]    dmem [DMEM_DEPTH];
    logic [DADDR_W-1:0] dmem_idx;

    assign instr  = ROM_IMAGE[pc[IADDR_W+1:2]];
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    // Anything not matched below keeps the NOP bundle: no writes, fall through to pc+4.
    // NOTE: assigning the full default before the case keeps this block free of latches.
    always_comb begin
        ctrl = CTRL_NOP;
        case (opcode)
            OP_R: begin
                ctrl.reg_we = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, F3_ADD_SUB}: ctrl.alu_op = ALU_ADD;
                    {F7_SUB,  F3_ADD_SUB}: ctrl.alu_op = ALU_SUB;
                    {F7_BASE, F3_AND}:     ctrl.alu_op = ALU_AND;
                    {F7_BASE, F3_OR}:      ctrl.alu_op = ALU_OR;
                    {F7_BASE, F3_SLT}:     ctrl.alu_op = ALU_SLT;
                    default:               ctrl.reg_we = 1'b0;
                endcase
            end
            OP_I: begin
                ctrl.reg_we  = 1'b1;
                ctrl.alu_src = 1'b1;
                case (funct3)
                    F3_ADD_SUB: ctrl.alu_op = ALU_ADD;
                    F3_AND:     ctrl.alu_op = ALU_AND;
                    F3_OR:      ctrl.alu_op = ALU_OR;
                    F3_SLT:     ctrl.alu_op = ALU_SLT;
                    default:    ctrl.reg_we = 1'b0;
                endcase
            end
            OP_LOAD: begin
                if (funct3 == F3_WORD) begin
                    ctrl.reg_we     = 1'b1;
                    ctrl.alu_src    = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
            end
            OP_STORE: begin
                if (funct3 == F3_WORD) begin
                    ctrl.mem_we  = 1'b1;
                    ctrl.alu_src = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3 == F3_BEQ) begin
                    ctrl.branch = 1'b1;
                    ctrl.alu_op = ALU_SUB;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        imm = '0;
        case (opcode)
            OP_STORE:  imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                              instr[30:25], instr[11:8], 1'b0};
            default:   imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
        endcase
    end

    riscv_regfile #(
        .XLEN (XLEN)
    ) regFile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data),
        .we     (ctrl.reg_we),
        .waddr  (rd),
        .wdata  (wb_data)
    );

    assign alu_b = ctrl.alu_src ? imm : rs2_data;

    always_comb begin
        alu_result = '0;
        case (ctrl.alu_op)
            ALU_ADD: alu_result = rs1_data + alu_b;
            ALU_SUB: alu_result = rs1_data - alu_b;
            ALU_AND: alu_result = rs1_data & alu_b;
            ALU_OR:  alu_result = rs1_data | alu_b;
            ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, $signed(rs1_data) < $signed(alu_b)};
            default: alu_result = '0;
        endcase
    end

    // Word-addressed RAM: the two byte-offset bits of the address are dropped.
    assign dmem_idx  = alu_result[DADDR_W+1:2];
    assign load_data = dmem[dmem_idx];
    assign wb_data   = ctrl.mem_to_reg ? load_data : alu_result;

    // NOTE: the RAM is cleared by the asynchronous reset, which forces it into
    // flops; a RAM macro could not offer this, so keep DMEM_DEPTH small.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
        end else if (ctrl.mem_we) begin
            dmem[dmem_idx] <= rs2_data;
        end
    end

    assign branch_taken = ctrl.branch && (rs1_data == rs2_data);
    assign pc_next      = (branch_taken ? (pc + imm) : (pc + XLEN'(4))) & PC_MASK;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc <= RESET_PC;
        else      pc <= pc_next;
    end

endmodule

// File: rtl/riscv_regfile.sv
// 32 x XLEN register file: two asynchronous read ports, one synchronous write port,
// asynchronous active-low clear, x0 hardwired to zero.
module riscv_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs [32];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; a same-cycle read therefore sees the old register contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/riscv_single_cycle_top.sv
// Self-contained single-cycle RV32I-subset processor; no external data interface,
// architectural state lives in the datapath instance.
module riscv_single_cycle_top
    import riscv_pkg::*;
#(
    parameter int              XLEN       = riscv_pkg::XLEN,
    parameter int              IMEM_DEPTH = 64,
    parameter int              DMEM_DEPTH = 64,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter rom_image_t      ROM_IMAGE  = DEFAULT_ROM
) (
    input logic clk,
    input logic rst
);

    riscv_datapath #(
        .XLEN       (XLEN),
        .IMEM_DEPTH (IMEM_DEPTH),
        .DMEM_DEPTH (DMEM_DEPTH),
        .RESET_PC   (RESET_PC),
        .ROM_IMAGE  (ROM_IMAGE)
    ) datapath (
        .clk (clk),
        .rst (rst)
    );

endmodule

// File: tb/tb_riscv_single_cycle_top.sv
// Bench for riscv_single_cycle_top: one core runs the built-in program, a second runs a
// directed program; both are compared against an instruction-level model of the ISA subset.
module tb_riscv_single_cycle_top;
    import riscv_pkg::*;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [4:0] rdst);
        return {f7, r2, r1, f3, rdst, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rdst,
                                          input logic [6:0] opc);
        logic [31:0] v;
        v = imm;
        return {v[11:0], r1, f3, rdst, opc};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input logic [4:0] r2,
                                          input logic [4:0] r1);
        logic [31:0] v;
        v = imm;
        return {v[11:5], r2, r1, 3'd2, v[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], r2, r1, f3, v[4:1], v[11], 7'h63};
    endfunction

    function automatic rom_image_t build_default_rom();
        rom_image_t r;
        for (int i = 0; i < 64; i++) r[i] = 32'h0000_0013;
        r[0] = 32'h0020_0093;
        r[1] = 32'h0040_0113;
        r[2] = 32'h4011_01B3;
        r[3] = 32'h4031_0233;
        r[4] = 32'h0020_82B3;
        r[5] = 32'h4012_8333;
        return r;
    endfunction

    function automatic rom_image_t build_test_rom();
        rom_image_t r;
        for (int i = 0; i < 64; i++) r[i] = 32'h0000_0013;
        r[0]  = enc_i(5, 5'd0, 3'd0, 5'd0, 7'h13);          // addi x0,x0,5
        r[1]  = enc_i(7, 5'd0, 3'd0, 5'd1, 7'h13);          // addi x1,x0,7
        r[2]  = enc_s(8, 5'd1, 5'd0);                       // sw   x1,8(x0)
        r[3]  = enc_i(8, 5'd0, 3'd2, 5'd2, 7'h03);          // lw   x2,8(x0)
        r[4]  = enc_b(8, 5'd0, 5'd0, 3'd0);                 // beq  x0,x0,+8
        r[5]  = enc_i(1, 5'd0, 3'd0, 5'd3, 7'h13);          // skipped
        r[6]  = enc_b(8, 5'd0, 5'd1, 3'd0);                 // beq  x1,x0,+8 (not taken)
        r[7]  = 32'hFFFF_FFFF;
        r[8]  = enc_i(-3, 5'd0, 3'd0, 5'd4, 7'h13);         // addi x4,x0,-3
        r[9]  = enc_r(7'h00, 5'd1, 5'd4, 3'd2, 5'd5);       // slt  x5,x4,x1
        r[10] = enc_i(-4, 5'd4, 3'd2, 5'd6, 7'h13);         // slti x6,x4,-4
        r[11] = enc_i(-2, 5'd4, 3'd2, 5'd13, 7'h13);        // slti x13,x4,-2
        r[12] = enc_i(3, 5'd1, 3'd7, 5'd7, 7'h13);          // andi x7,x1,3
        r[13] = enc_i(16, 5'd1, 3'd6, 5'd8, 7'h13);         // ori  x8,x1,16
        r[14] = enc_r(7'h00, 5'd4, 5'd1, 3'd7, 5'd9);       // and  x9,x1,x4
        r[15] = enc_r(7'h00, 5'd4, 5'd1, 3'd6, 5'd10);      // or   x10,x1,x4
        r[16] = enc_r(7'h20, 5'd1, 5'd4, 3'd0, 5'd11);      // sub  x11,x4,x1
        r[17] = enc_r(7'h00, 5'd4, 5'd4, 3'd0, 5'd12);      // add  x12,x4,x4
        r[18] = enc_s(-4, 5'd4, 5'd1);                      // sw   x4,-4(x1)
        r[19] = enc_i(1, 5'd0, 3'd2, 5'd14, 7'h03);         // lw   x14,1(x0)
        r[20] = enc_r(7'h00, 5'd1, 5'd1, 3'd1, 5'd15);      // sll (unsupported)
        r[21] = enc_b(8, 5'd0, 5'd1, 3'd1);                 // bne (unsupported)
        r[22] = enc_i(8, 5'd0, 3'd0, 5'd16, 7'h03);         // lb  (unsupported)
        r[23] = enc_r(7'h01, 5'd1, 5'd1, 3'd0, 5'd17);      // mul (unsupported)
        r[61] = enc_b(8, 5'd0, 5'd0, 3'd0);                 // beq  x0,x0,+8
        r[62] = enc_i(9, 5'd0, 3'd0, 5'd3, 7'h13);          // skipped
        return r;
    endfunction

    localparam rom_image_t BENCH_DEFAULT_ROM = build_default_rom();
    localparam rom_image_t TEST_ROM          = build_test_rom();

    logic clk = 1'b0;
    logic rst_d = 1'b0;
    logic rst_t = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    riscv_single_cycle_top dut (
        .clk (clk),
        .rst (rst_d)
    );

    riscv_single_cycle_top #(
        .ROM_IMAGE (TEST_ROM)
    ) dut_t (
        .clk (clk),
        .rst (rst_t)
    );

    logic [31:0] m_regs [32];
    logic [31:0] m_dmem [64];
    logic [31:0] m_pc;
    logic [31:0] def_expect [7];

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        for (int i = 0; i < 64; i++) m_dmem[i] = '0;
        m_pc = '0;
    endtask

    // Executes one instruction straight from the ISA rules.
    task automatic model_step(input rom_image_t rom);
        logic [31:0] insn, a, b, imm_i, imm_s, imm_b, val, addr, next_pc;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic        wr;
        int          rdst;
        insn  = rom[m_pc[7:2]];
        opc   = insn[6:0];
        f3    = insn[14:12];
        f7    = insn[31:25];
        rdst  = int'(insn[11:7]);
        a     = m_regs[insn[19:15]];
        b     = m_regs[insn[24:20]];
        imm_i = 32'($signed(insn[31:20]));
        imm_s = 32'($signed({insn[31:25], insn[11:7]}));
        imm_b = 32'($signed({insn[31], insn[7], insn[30:25], insn[11:8], 1'b0}));
        next_pc = m_pc + 32'd4;
        wr  = 1'b0;
        val = '0;
        case (opc)
            7'h33: begin
                wr = 1'b1;
                if      (f7 == 7'h00 && f3 == 3'd0) val = a + b;
                else if (f7 == 7'h20 && f3 == 3'd0) val = a - b;
                else if (f7 == 7'h00 && f3 == 3'd7) val = a & b;
                else if (f7 == 7'h00 && f3 == 3'd6) val = a | b;
                else if (f7 == 7'h00 && f3 == 3'd2) val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                else wr = 1'b0;
            end
            7'h13: begin
                wr = 1'b1;
                if      (f3 == 3'd0) val = a + imm_i;
                else if (f3 == 3'd7) val = a & imm_i;
                else if (f3 == 3'd6) val = a | imm_i;
                else if (f3 == 3'd2) val = ($signed(a) < $signed(imm_i)) ? 32'd1 : 32'd0;
                else wr = 1'b0;
            end
            7'h03: if (f3 == 3'd2) begin
                addr = a + imm_i;
                val  = m_dmem[addr[7:2]];
                wr   = 1'b1;
            end
            7'h23: if (f3 == 3'd2) begin
                addr = a + imm_s;
                m_dmem[addr[7:2]] = b;
            end
            7'h63: if (f3 == 3'd0 && a == b) next_pc = m_pc + imm_b;
            default: ;
        endcase
        if (wr && rdst != 0) m_regs[rdst] = val;
        m_pc = next_pc & 32'h0000_00FF;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (dut.datapath.pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_pc: got %h expected %h", dut.datapath.pc, 32'h0);
        end
        for (int i = 0; i < 32; i++) begin
            n_tests++;
            if (dut.datapath.regFile.regs[i] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_x%0d: got %h expected 0", i, dut.datapath.regFile.regs[i]);
            end
        end
        for (int i = 0; i < 64; i++) begin
            n_tests++;
            if (dut.datapath.dmem[i] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_dmem%0d: got %h expected 0", i, dut.datapath.dmem[i]);
            end
        end
        n_tests++;
        if (dut_t.datapath.pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_pc_t: got %h expected 0", dut_t.datapath.pc);
        end
    endtask

    task automatic test_default_program();
        @(negedge clk);
        rst_d = 1'b1;
        model_reset();
        repeat (20) begin
            @(negedge clk);
            model_step(BENCH_DEFAULT_ROM);
            n_tests++;
            if (dut.datapath.pc !== m_pc) begin
                n_fail++;
                $display("FAIL default_pc: got %h expected %h", dut.datapath.pc, m_pc);
            end
        end
        for (int i = 0; i < 32; i++) begin
            n_tests++;
            if (dut.datapath.regFile.regs[i] !== ((i < 7) ? def_expect[i] : 32'h0)) begin
                n_fail++;
                $display("FAIL default_x%0d: got %h expected %h", i,
                         dut.datapath.regFile.regs[i], (i < 7) ? def_expect[i] : 32'h0);
            end
        end
    endtask

    task automatic test_mid_reset();
        int d;
        int k;
        @(negedge clk);
        rst_d = 1'b0;
        @(negedge clk);
        rst_d = 1'b1;
        repeat (3) @(negedge clk);
        d = $urandom_range(1, 3);
        #(d);
        rst_d = 1'b0;
        #1;
        n_tests++;
        if (dut.datapath.pc !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset_pc: got %h expected 0", dut.datapath.pc);
        end
        for (int i = 1; i < 32; i++) begin
            n_tests++;
            if (dut.datapath.regFile.regs[i] !== 32'h0) begin
                n_fail++;
                $display("FAIL async_reset_x%0d: got %h expected 0", i, dut.datapath.regFile.regs[i]);
            end
        end
        @(negedge clk);
        rst_d = 1'b1;
        repeat (6) @(negedge clk);
        for (int i = 1; i < 7; i++) begin
            n_tests++;
            if (dut.datapath.regFile.regs[i] !== def_expect[i]) begin
                n_fail++;
                $display("FAIL rerun_x%0d: got %h expected %h", i,
                         dut.datapath.regFile.regs[i], def_expect[i]);
            end
        end
        n_tests++;
        if (dut.datapath.pc !== 32'd24) begin
            n_fail++;
            $display("FAIL rerun_pc: got %h expected %h", dut.datapath.pc, 32'd24);
        end
        repeat (4) begin
            k = $urandom_range(1, 90);
            d = $urandom_range(1, 4);
            #(d);
            rst_d = 1'b0;
            model_reset();
            @(negedge clk);
            rst_d = 1'b1;
            repeat (k) begin
                @(negedge clk);
                model_step(BENCH_DEFAULT_ROM);
            end
            n_tests++;
            if (dut.datapath.pc !== m_pc) begin
                n_fail++;
                $display("FAIL random_run_pc (k=%0d): got %h expected %h", k, dut.datapath.pc, m_pc);
            end
            for (int i = 0; i < 32; i++) begin
                n_tests++;
                if (dut.datapath.regFile.regs[i] !== m_regs[i]) begin
                    n_fail++;
                    $display("FAIL random_run_x%0d (k=%0d): got %h expected %h", i, k,
                             dut.datapath.regFile.regs[i], m_regs[i]);
                end
            end
        end
    endtask

    task automatic test_x0_protect();
        @(negedge clk);
        rst_t = 1'b1;
        model_reset();
        @(negedge clk);
        model_step(TEST_ROM);
        n_tests++;
        if (dut_t.datapath.regFile.regs[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL x0_write: got %h expected 0", dut_t.datapath.regFile.regs[0]);
        end
        n_tests++;
        if (dut_t.datapath.pc !== 32'd4) begin
            n_fail++;
            $display("FAIL x0_pc: got %h expected %h", dut_t.datapath.pc, 32'd4);
        end
    endtask

    task automatic test_mem_roundtrip();
        repeat (3) begin
            @(negedge clk);
            model_step(TEST_ROM);
        end
        n_tests++;
        if (dut_t.datapath.regFile.regs[2] !== 32'd7) begin
            n_fail++;
            $display("FAIL lw_x2: got %h expected %h", dut_t.datapath.regFile.regs[2], 32'd7);
        end
        n_tests++;
        if (dut_t.datapath.dmem[2] !== 32'd7) begin
            n_fail++;
            $display("FAIL sw_dmem2: got %h expected %h", dut_t.datapath.dmem[2], 32'd7);
        end
    endtask

    task automatic test_branch();
        @(negedge clk);
        model_step(TEST_ROM);
        n_tests++;
        if (dut_t.datapath.pc !== 32'd24) begin
            n_fail++;
            $display("FAIL beq_taken_pc: got %h expected %h", dut_t.datapath.pc, 32'd24);
        end
        @(negedge clk);
        model_step(TEST_ROM);
        n_tests++;
        if (dut_t.datapath.pc !== 32'd28) begin
            n_fail++;
            $display("FAIL beq_not_taken_pc: got %h expected %h", dut_t.datapath.pc, 32'd28);
        end
        n_tests++;
        if (dut_t.datapath.regFile.regs[3] !== 32'h0) begin
            n_fail++;
            $display("FAIL beq_skip_x3: got %h expected 0", dut_t.datapath.regFile.regs[3]);
        end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        model_step(TEST_ROM);
        n_tests++;
        if (dut_t.datapath.pc !== 32'd32) begin
            n_fail++;
            $display("FAIL illegal_pc: got %h expected %h", dut_t.datapath.pc, 32'd32);
        end
        for (int i = 0; i < 32; i++) begin
            n_tests++;
            if (dut_t.datapath.regFile.regs[i] !== m_regs[i]) begin
                n_fail++;
                $display("FAIL illegal_x%0d: got %h expected %h", i,
                         dut_t.datapath.regFile.regs[i], m_regs[i]);
            end
        end
        for (int i = 0; i < 64; i++) begin
            n_tests++;
            if (dut_t.datapath.dmem[i] !== m_dmem[i]) begin
                n_fail++;
                $display("FAIL illegal_dmem%0d: got %h expected %h", i,
                         dut_t.datapath.dmem[i], m_dmem[i]);
            end
        end
    endtask

    task automatic test_alu_mix();
        logic [31:0] exp_val [18];
        repeat (16) begin
            @(negedge clk);
            model_step(TEST_ROM);
            n_tests++;
            if (dut_t.datapath.pc !== m_pc) begin
                n_fail++;
                $display("FAIL alu_mix_pc: got %h expected %h", dut_t.datapath.pc, m_pc);
            end
        end
        for (int i = 0; i < 18; i++) exp_val[i] = '0;
        exp_val[1]  = 32'd7;
        exp_val[2]  = 32'd7;
        exp_val[4]  = 32'hFFFF_FFFD;
        exp_val[5]  = 32'd1;
        exp_val[6]  = 32'd0;
        exp_val[7]  = 32'd3;
        exp_val[8]  = 32'h17;
        exp_val[9]  = 32'd5;
        exp_val[10] = 32'hFFFF_FFFF;
        exp_val[11] = 32'hFFFF_FFF6;
        exp_val[12] = 32'hFFFF_FFFA;
        exp_val[13] = 32'd1;
        exp_val[14] = 32'hFFFF_FFFD;
        for (int i = 0; i < 18; i++) begin
            n_tests++;
            if (dut_t.datapath.regFile.regs[i] !== exp_val[i]) begin
                n_fail++;
                $display("FAIL alu_mix_x%0d: got %h expected %h", i,
                         dut_t.datapath.regFile.regs[i], exp_val[i]);
            end
        end
        n_tests++;
        if (dut_t.datapath.dmem[0] !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL neg_offset_store: got %h expected %h", dut_t.datapath.dmem[0], 32'hFFFF_FFFD);
        end
        n_tests++;
        if (dut_t.datapath.pc !== 32'd96) begin
            n_fail++;
            $display("FAIL alu_mix_end_pc: got %h expected %h", dut_t.datapath.pc, 32'd96);
        end
    endtask

    task automatic test_wrap_random();
        int k;
        k = 40 + $urandom_range(0, 60);
        repeat (k) begin
            @(negedge clk);
            model_step(TEST_ROM);
            n_tests++;
            if (dut_t.datapath.pc !== m_pc) begin
                n_fail++;
                $display("FAIL wrap_pc: got %h expected %h", dut_t.datapath.pc, m_pc);
            end
        end
        for (int i = 0; i < 32; i++) begin
            n_tests++;
            if (dut_t.datapath.regFile.regs[i] !== m_regs[i]) begin
                n_fail++;
                $display("FAIL wrap_x%0d: got %h expected %h", i,
                         dut_t.datapath.regFile.regs[i], m_regs[i]);
            end
        end
        for (int i = 0; i < 64; i++) begin
            n_tests++;
            if (dut_t.datapath.dmem[i] !== m_dmem[i]) begin
                n_fail++;
                $display("FAIL wrap_dmem%0d: got %h expected %h", i,
                         dut_t.datapath.dmem[i], m_dmem[i]);
            end
        end
        n_tests++;
        if (dut_t.datapath.regFile.regs[3] !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_skip_x3: got %h expected 0", dut_t.datapath.regFile.regs[3]);
        end
    endtask

    initial begin
        def_expect[0] = 32'd0;
        def_expect[1] = 32'd2;
        def_expect[2] = 32'd4;
        def_expect[3] = 32'd2;
        def_expect[4] = 32'd2;
        def_expect[5] = 32'd6;
        def_expect[6] = 32'd4;
        test_reset();
        test_default_program();
        test_mid_reset();
        test_x0_protect();
        test_mem_roundtrip();
        test_branch();
        test_illegal();
        test_alu_mix();
        test_wrap_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/riscv_single_cycle_top.md
Name: riscv_single_cycle_top

Overview:
Self-contained single-cycle RV32I-subset processor: PC, instruction ROM, control decoder, 32x32 register file, ALU and data RAM.
- Each rising clock edge retires one instruction.
- Top-level integration block with no external data interface; verification reads architectural state hierarchically.
- Instruction ROM holds a fixed default program.

Parameters:
- XLEN, 32, datapath and register width
- IMEM_DEPTH, 64, instruction ROM words (word-addressed by pc[7:2])
- DMEM_DEPTH, 64, data RAM words (word-addressed by addr[7:2])
- RESET_PC, 32'h0, PC value after reset

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset

Behaviour:
- Reset (rst=0, asynchronous): PC=RESET_PC; all 32 registers=0; data RAM cleared to 0. Execution starts on the first rising edge after rst=1.
- Per cycle, combinationally: fetch imem[pc[7:2]], decode, read rs1/rs2, compute ALU result, read dmem. On the rising edge: write rd, write dmem (sw), update PC. Latency is one cycle per instruction.
- Supported R-type (opcode 0x33): add, sub (funct7=0x20), and, or, slt (signed).
- Supported I-type (opcode 0x13): addi, andi, ori, slti. Immediates are sign-extended 12-bit.
- Supported loads/stores: lw (0x03), sw (0x23); word only, byte offset ignored.
- Supported branch: beq (0x63), taken target pc+sext(imm13). Otherwise next PC is pc+4.
- x0 reads as 0; writes to x0 are discarded.
- Register file: two async read ports, one sync write port; write-enable is asserted only for R-type, I-type ALU and lw.
- Read-during-write to the same register returns the old value; the new value is visible next cycle.
- Any unsupported opcode/funct executes as a NOP (no reg or mem write, pc+4).
- PC wraps modulo IMEM_DEPTH*4.
- Default ROM program, words 0-5:
  - 0x00200093: addi x1,x0,2
  - 0x00400113: addi x2,x0,4
  - 0x401101B3: sub x3,x2,x1
  - 0x40310233: sub x4,x2,x3
  - 0x002082B3: add x5,x1,x2
  - 0x40128333: sub x6,x5,x1
- All remaining ROM words are 0x00000013 (NOP). Re-execution after PC wrap produces identical register values.
- ALU arithmetic is modulo 2^32; overflow is ignored.
- Hierarchy: instance named datapath contains register file instance regFile. Each register's stored value is probe-able by index 1..31.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH)
  - funct3/funct7 constants
  - alu_op_t enum (ADD, SUB, AND, OR, SLT)
  - ctrl_t struct: reg_we, alu_src, mem_we, mem_to_reg, branch, alu_op
  - XLEN
- Natural sub-module: regfile (32x32, 2R/1W, async active-low clear, x0 hardwired).
- Decoder, ALU and memories stay inline in datapath/top.

Test Plan:
- Reset then run: rst=0 for one cycle, release, run 20 cycles -> x1=2, x2=4, x3=2, x4=2, x5=6, x6=4; x7..x31=0; x0=0.
- Mid-run reset: pull rst low asynchronously after 3 instructions -> PC=0 and all registers=0 immediately (no clock needed). After release, the same final values are reached 6 cycles later.
- x0 protection: ROM word addi x0,x0,5 -> x0 still reads 0, PC advances by 4.
- Memory round-trip: program addi x1,x0,7; sw x1,8(x0); lw x2,8(x0) -> x2=7 after 3 cycles; dmem word 2 = 7.
- Branch: beq x0,x0,+8 -> the next instruction is skipped and PC advances by 8; with unequal operands PC advances by 4.
- Illegal opcode 0xFFFFFFFF -> no state change except PC+4.
